// File: rtl/fp_fmt_pkg.sv
// Shared floating-point format helpers for the narrowing converter:
// exponent constants, flag bit positions, rounding encodings and lane classes.
package fp_fmt_pkg;

  localparam int FLAG_OVF = 0;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INX = 2;
  localparam int NFLAGS   = 3;

  localparam logic RND_RTZ = 1'b0;
  localparam logic RND_RNE = 1'b1;

  typedef enum logic [2:0] {
    CLS_NORM = 3'd0,
    CLS_ZERO = 3'd1,
    CLS_UNF  = 3'd2,
    CLS_OVF  = 3'd3,
    CLS_INF  = 3'd4,
    CLS_NAN  = 3'd5
  } fp_class_e;

  function automatic int fp_bias(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int fp_exp_ones(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/fp_narrow_lane.sv
// One conversion lane: stage 1 classifies and splits the fraction,
// stage 2 rounds, packs and produces {inexact, underflow, overflow}.
module fp_narrow_lane
  import fp_fmt_pkg::*;
#(
  parameter int IN_EXP  = 8,
  parameter int IN_MAN  = 23,
  parameter int OUT_EXP = 5,
  parameter int OUT_MAN = 10
) (
  input  logic                       aclk,
  input  logic                       rstn,
  input  logic                       ld1,
  input  logic                       ld2,
  input  logic                       rnd_mode,
  input  logic [IN_EXP+IN_MAN:0]     in_word,
  output logic [OUT_EXP+OUT_MAN:0]   out_word,
  output logic [NFLAGS-1:0]          out_flags
);

  localparam int EW = IN_EXP + 2;
  localparam int OW = 1 + OUT_EXP + OUT_MAN;
  localparam logic [IN_EXP-1:0]     IN_ONES   = {IN_EXP{1'b1}};
  localparam logic [OUT_EXP-1:0]    OUT_ONES  = {OUT_EXP{1'b1}};
  localparam logic [OUT_EXP-1:0]    OUT_EMAX  = {OUT_ONES[OUT_EXP-1:1], 1'b0};
  localparam logic signed [EW-1:0]  BIAS_DIFF = EW'(fp_bias(IN_EXP) - fp_bias(OUT_EXP));
  localparam logic signed [EW-1:0]  E_OVF     = EW'(fp_exp_ones(OUT_EXP));
  localparam logic signed [EW-1:0]  E_ZERO    = '0;

  logic                 in_sign_s;
  logic [IN_EXP-1:0]    in_exp_s;
  logic [IN_MAN-1:0]    in_frac_s;
  logic [IN_MAN-1:0]    rest_s;

  fp_class_e            s1_cls_d, s1_cls_q;
  logic                 s1_sign_d, s1_sign_q;
  logic signed [EW-1:0] s1_exp_d, s1_exp_q;
  logic [OUT_MAN-1:0]   s1_frac_d, s1_frac_q;
  logic                 s1_g_d, s1_g_q;
  logic                 s1_st_d, s1_st_q;
  logic                 s1_rnd_d, s1_rnd_q;

  logic                 inc_s;
  logic [OUT_MAN:0]     sum_s;
  logic signed [EW-1:0] exp_n_s;
  logic [OW-1:0]        out_word_d, out_word_q;
  logic [NFLAGS-1:0]    out_flags_d, out_flags_q;

  assign {in_sign_s, in_exp_s, in_frac_s} = in_word;

  // Stage 1: re-bias exponent, split fraction into kept/guard/sticky, classify.
  always_comb begin
    s1_sign_d = in_sign_s;
    s1_rnd_d  = rnd_mode;
    s1_exp_d  = $signed({2'b00, in_exp_s}) - BIAS_DIFF;
    s1_frac_d = in_frac_s[IN_MAN-1 -: OUT_MAN];
    s1_g_d    = in_frac_s[IN_MAN-OUT_MAN-1];
    rest_s    = in_frac_s << (OUT_MAN + 1);
    s1_st_d   = |rest_s;
    if (in_exp_s == IN_ONES) begin
      s1_cls_d = (|in_frac_s) ? CLS_NAN : CLS_INF;
    end else if (in_exp_s == '0) begin
      s1_cls_d = (|in_frac_s) ? CLS_UNF : CLS_ZERO;
    end else if (s1_exp_d <= E_ZERO) begin
      s1_cls_d = CLS_UNF;
    end else if (s1_exp_d >= E_OVF) begin
      s1_cls_d = CLS_OVF;
    end else begin
      s1_cls_d = CLS_NORM;
    end
  end

  // Stage 1 registers, loaded only when a beat is accepted.
  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      s1_cls_q  <= CLS_ZERO;
      s1_sign_q <= 1'b0;
      s1_exp_q  <= '0;
      s1_frac_q <= '0;
      s1_g_q    <= 1'b0;
      s1_st_q   <= 1'b0;
      s1_rnd_q  <= 1'b0;
    end else if (ld1) begin
      s1_cls_q  <= s1_cls_d;
      s1_sign_q <= s1_sign_d;
      s1_exp_q  <= s1_exp_d;
      s1_frac_q <= s1_frac_d;
      s1_g_q    <= s1_g_d;
      s1_st_q   <= s1_st_d;
      s1_rnd_q  <= s1_rnd_d;
    end
  end

  // Stage 2: round, propagate a fraction carry into the exponent, pack.
  always_comb begin
    inc_s       = (s1_rnd_q == RND_RNE) && s1_g_q && (s1_st_q || s1_frac_q[0]);
    sum_s       = {1'b0, s1_frac_q} + {{OUT_MAN{1'b0}}, inc_s};
    exp_n_s     = s1_exp_q + $signed({{(EW-1){1'b0}}, sum_s[OUT_MAN]});
    out_word_d  = '0;
    out_flags_d = '0;
    case (s1_cls_q)
      CLS_NAN: out_word_d = {s1_sign_q, OUT_ONES, 1'b1, {(OUT_MAN-1){1'b0}}};
      CLS_INF: out_word_d = {s1_sign_q, OUT_ONES, {OUT_MAN{1'b0}}};
      CLS_ZERO: out_word_d = {s1_sign_q, {(OUT_EXP+OUT_MAN){1'b0}}};
      CLS_UNF: begin
        out_word_d            = {s1_sign_q, {(OUT_EXP+OUT_MAN){1'b0}}};
        out_flags_d[FLAG_UNF] = 1'b1;
        out_flags_d[FLAG_INX] = 1'b1;
      end
      CLS_OVF: begin
        out_flags_d[FLAG_OVF] = 1'b1;
        out_flags_d[FLAG_INX] = 1'b1;
        if (s1_rnd_q == RND_RTZ) begin
          out_word_d = {s1_sign_q, OUT_EMAX, {OUT_MAN{1'b1}}};
        end else begin
          out_word_d = {s1_sign_q, OUT_ONES, {OUT_MAN{1'b0}}};
        end
      end
      CLS_NORM: begin
        out_flags_d[FLAG_INX] = s1_g_q | s1_st_q;
        if (exp_n_s >= E_OVF) begin
          out_word_d            = {s1_sign_q, OUT_ONES, {OUT_MAN{1'b0}}};
          out_flags_d[FLAG_OVF] = 1'b1;
        end else begin
          out_word_d = {s1_sign_q, exp_n_s[OUT_EXP-1:0], sum_s[OUT_MAN-1:0]};
        end
      end
      default: begin
        out_word_d  = '0;
        out_flags_d = '0;
      end
    endcase
  end

  // Stage 2 registers drive the output beat and hold while stalled.
  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      out_word_q  <= '0;
      out_flags_q <= '0;
    end else if (ld2) begin
      out_word_q  <= out_word_d;
      out_flags_q <= out_flags_d;
    end
  end

  assign out_word  = out_word_q;
  assign out_flags = out_flags_q;

endmodule

// File: rtl/float_narrow_convert_pipe.sv
// Multi-lane narrowing float converter: two-stage valid/ready pipeline with
// global clock enable and per-lane sticky exception flags.
module float_narrow_convert_pipe
  import fp_fmt_pkg::*;
#(
  parameter int IN_EXP  = 8,
  parameter int IN_MAN  = 23,
  parameter int OUT_EXP = 5,
  parameter int OUT_MAN = 10,
  parameter int LANES   = 1
) (
  input  logic                               aclk,
  input  logic                               rstn,
  input  logic                               clken,
  input  logic                               rnd_mode,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [LANES*(1+IN_EXP+IN_MAN)-1:0] s_data,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [LANES*(1+OUT_EXP+OUT_MAN)-1:0] m_data,
  output logic [LANES*NFLAGS-1:0]            m_flags,
  input  logic                               clr_flags,
  output logic [LANES*NFLAGS-1:0]            sticky_flags
);

  localparam int IW = 1 + IN_EXP + IN_MAN;
  localparam int OW = 1 + OUT_EXP + OUT_MAN;

  logic                      adv1_s, adv2_s, ld1_s, ld2_s, hs_s;
  logic                      v1_d, v1_q, v2_d, v2_q;
  logic [LANES*NFLAGS-1:0]   sticky_d, sticky_q;

  // Handshake control; a clear coinciding with a handoff keeps that beat's flags.
  always_comb begin
    adv2_s = clken && (!v2_q || m_ready);
    adv1_s = clken && (!v1_q || adv2_s);
    ld1_s  = adv1_s && s_valid;
    ld2_s  = adv2_s && v1_q;
    v1_d   = adv1_s ? s_valid : v1_q;
    v2_d   = adv2_s ? v1_q : v2_q;
    hs_s   = clken && v2_q && m_ready;
    if (clken && clr_flags) begin
      sticky_d = hs_s ? m_flags : '0;
    end else if (hs_s) begin
      sticky_d = sticky_q | m_flags;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // Stage valid bits and sticky flag accumulator.
  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      sticky_q <= '0;
    end else begin
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      sticky_q <= sticky_d;
    end
  end

  assign s_ready      = adv1_s;
  assign m_valid      = v2_q;
  assign sticky_flags = sticky_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fp_narrow_lane #(
      .IN_EXP  (IN_EXP),
      .IN_MAN  (IN_MAN),
      .OUT_EXP (OUT_EXP),
      .OUT_MAN (OUT_MAN)
    ) u_lane (
      .aclk      (aclk),
      .rstn      (rstn),
      .ld1       (ld1_s),
      .ld2       (ld2_s),
      .rnd_mode  (rnd_mode),
      .in_word   (s_data[i*IW +: IW]),
      .out_word  (m_data[i*OW +: OW]),
      .out_flags (m_flags[i*NFLAGS +: NFLAGS])
    );
  end

endmodule

// File: tb/tb_float_narrow_convert_pipe.sv
// Directed bench for float_narrow_convert_pipe (4-lane build): conversions,
// rounding, specials, backpressure, clock enable, reset and sticky flags.
module tb_float_narrow_convert_pipe;

  localparam int LANES = 4;

  logic                  aclk = 1'b0;
  logic                  rstn = 1'b0;
  logic                  clken = 1'b0;
  logic                  rnd_mode = 1'b0;
  logic                  s_valid = 1'b0;
  logic                  s_ready;
  logic [LANES*32-1:0]   s_data = '0;
  logic                  m_valid;
  logic                  m_ready = 1'b0;
  logic [LANES*16-1:0]   m_data;
  logic [LANES*3-1:0]    m_flags;
  logic                  clr_flags = 1'b0;
  logic [LANES*3-1:0]    sticky_flags;

  int checks = 0;
  int errors = 0;
  int k, nout;
  logic        accepted;
  logic [31:0] beat;

  float_narrow_convert_pipe #(
    .IN_EXP(8), .IN_MAN(23), .OUT_EXP(5), .OUT_MAN(10), .LANES(LANES)
  ) u_dut (
    .aclk(aclk), .rstn(rstn), .clken(clken), .rnd_mode(rnd_mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_flags(m_flags),
    .clr_flags(clr_flags), .sticky_flags(sticky_flags)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  // Send one beat with m_ready high; returns with the result visible on m_*.
  task automatic runraw(input string tag, input logic [127:0] sd, input logic rnd,
                        input logic [63:0] ed, input logic [11:0] ef);
    s_valid = 1'b1; s_data = sd; rnd_mode = rnd; m_ready = 1'b1;
    #1;
    chk({tag, "_srdy"}, s_ready, 1'b1);
    cyc();
    s_valid = 1'b0;
    #1;
    chk({tag, "_lat"}, m_valid, 1'b0);
    cyc();
    chk({tag, "_mv"}, m_valid, 1'b1);
    chk({tag, "_data"}, m_data, ed);
    chk({tag, "_flags"}, m_flags, ef);
  endtask

  task automatic run1(input string tag, input logic [31:0] x, input logic rnd,
                      input logic [15:0] ed, input logic [2:0] ef);
    runraw(tag, {LANES{x}}, rnd, {LANES{ed}}, {LANES{ef}});
  endtask

  initial begin
    clken = 1'b1;
    cyc(); cyc();
    chk("rst_mvalid", m_valid, 1'b0);
    chk("rst_mdata", m_data, 64'h0);
    chk("rst_mflags", m_flags, 12'h0);
    chk("rst_sticky", sticky_flags, 12'h0);
    rstn = 1'b1;
    #1;
    chk("rst_srdy", s_ready, 1'b1);
    cyc();

    run1("one",       32'h3F800000, 1'b1, 16'h3C00, 3'd0);
    run1("rne_up",    32'h3F803000, 1'b1, 16'h3C02, 3'd4);
    run1("rtz_up",    32'h3F803000, 1'b0, 16'h3C01, 3'd4);
    run1("tie_even",  32'h3F801000, 1'b1, 16'h3C00, 3'd4);
    run1("exact",     32'h3F802000, 1'b1, 16'h3C01, 3'd0);
    run1("ovf_carry", 32'h477FF000, 1'b1, 16'h7C00, 3'd5);
    run1("ovf_rtz",   32'h477FF000, 1'b0, 16'h7BFF, 3'd4);
    run1("big_rne",   32'h4F000000, 1'b1, 16'h7C00, 3'd5);
    run1("big_rtz",   32'h4F000000, 1'b0, 16'h7BFF, 3'd5);
    run1("unf_pos",   32'h322BCC77, 1'b1, 16'h0000, 3'd6);
    run1("unf_neg",   32'hB22BCC77, 1'b1, 16'h8000, 3'd6);
    run1("nan",       32'h7FC00001, 1'b1, 16'h7E00, 3'd0);
    run1("ninf",      32'hFF800000, 1'b1, 16'hFC00, 3'd0);
    run1("nzero",     32'h80000000, 1'b1, 16'h8000, 3'd0);
    run1("subn",      32'h00000001, 1'b1, 16'h0000, 3'd6);
    cyc();
    chk("sticky_all", sticky_flags, {LANES{3'b111}});

    // Backpressure: 8 beats, m_ready low for the first 5 cycles.
    m_ready = 1'b0; k = 0; nout = 0; rnd_mode = 1'b1;
    for (int c = 0; c < 40 && nout < 8; c++) begin
      m_ready = (c >= 5);
      s_valid = (k < 8);
      beat = 32'h3F800000 | (32'(k) << 13);
      s_data = {LANES{beat}};
      #1;
      if (c >= 2 && c < 5) begin
        chk("bp_srdy_low", s_ready, 1'b0);
        chk("bp_hold_data", m_data, {LANES{16'h3C00}});
        chk("bp_hold_valid", m_valid, 1'b1);
      end
      if (m_valid && m_ready) begin
        chk("bp_order", m_data, {LANES{16'h3C00 + 16'(nout)}});
        nout++;
      end
      accepted = s_valid && s_ready;
      cyc();
      if (accepted) k++;
    end
    s_valid = 1'b0;
    chk("bp_count_out", 64'(nout), 64'd8);
    chk("bp_count_in", 64'(k), 64'd8);
    #1;
    chk("bp_drained", m_valid, 1'b0);

    // Clock enable low for 3 cycles with one beat in each stage.
    m_ready = 1'b1; s_valid = 1'b1; s_data = {LANES{32'h3F802000}};
    cyc();
    s_data = {LANES{32'h3F804000}};
    cyc();
    clken = 1'b0; s_data = {LANES{32'h3F806000}};
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("ce_srdy", s_ready, 1'b0);
      chk("ce_mvalid", m_valid, 1'b1);
      chk("ce_mdata", m_data, {LANES{16'h3C01}});
      cyc();
    end
    clken = 1'b1; s_valid = 1'b0;
    #1;
    chk("ce_resume_a", m_data, {LANES{16'h3C01}});
    cyc();
    chk("ce_resume_b", m_data, {LANES{16'h3C02}});
    chk("ce_resume_bv", m_valid, 1'b1);
    cyc();
    chk("ce_empty", m_valid, 1'b0);

    // Reset with two beats in flight.
    m_ready = 1'b0; s_valid = 1'b1; s_data = {LANES{32'h3F800000}};
    cyc();
    s_data = {LANES{32'h3F802000}};
    cyc();
    s_valid = 1'b0;
    #1;
    chk("rr_pre_mvalid", m_valid, 1'b1);
    rstn = 1'b0;
    #1;
    chk("rr_mvalid", m_valid, 1'b0);
    chk("rr_mdata", m_data, 64'h0);
    chk("rr_sticky", sticky_flags, 12'h0);
    cyc();
    rstn = 1'b1; m_ready = 1'b1;
    #1;
    chk("rr_srdy", s_ready, 1'b1);
    cyc(); cyc();
    chk("rr_gone", m_valid, 1'b0);

    // Sticky accumulate, clear, and clear coinciding with a handoff.
    run1("st_ovf", 32'h4F000000, 1'b1, 16'h7C00, 3'd5);
    chk("st_before_hs", sticky_flags, 12'h0);
    cyc();
    chk("st_ovf_set", sticky_flags, {LANES{3'd5}});
    clr_flags = 1'b1;
    cyc();
    clr_flags = 1'b0;
    chk("st_cleared", sticky_flags, 12'h0);
    run1("st_ovf2", 32'h4F000000, 1'b1, 16'h7C00, 3'd5);
    cyc();
    chk("st_ovf2_set", sticky_flags, {LANES{3'd5}});
    run1("st_inx", 32'h3F801000, 1'b1, 16'h3C00, 3'd4);
    clr_flags = 1'b1;
    cyc();
    clr_flags = 1'b0;
    chk("st_clr_hs", sticky_flags, {LANES{3'd4}});

    // Independent lanes.
    runraw("lanes",
           {32'h7FC00001, 32'hB22BCC77, 32'h477FF000, 32'h3F803000}, 1'b1,
           {16'h7E00, 16'h8000, 16'h7C00, 16'h3C02},
           {3'd0, 3'd6, 3'd5, 3'd4});
    cyc();
    chk("lanes_sticky", sticky_flags, {3'd0, 3'd6, 3'd5, 3'd4} | {LANES{3'd4}});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/float_narrow_convert_pipe.md
Name: float_narrow_convert_pipe

Overview:
Parametrised, multi-lane floating-point narrowing converter. It converts IEEE-style (1, IN_EXP, IN_MAN) operands to (1, OUT_EXP, OUT_MAN), with selectable rounding, NaN/Inf handling and overflow/underflow/inexact flags.
- Two-stage pipeline with valid/ready backpressure.
- Sticky status flags per lane.
- Sits in the disparity-to-depth path ahead of half-precision storage and bus packing.

Parameters:
- IN_EXP, 8, input exponent width
- IN_MAN, 23, input fraction width
- OUT_EXP, 5, output exponent width (OUT_EXP <= IN_EXP)
- OUT_MAN, 10, output fraction width (OUT_MAN < IN_MAN)
- LANES, 1, independent parallel lanes sharing one handshake

Ports:
- aclk  in  1  clock
- rstn  in  1  reset
- clken  in  1  global clock enable; 0 freezes all state
- rnd_mode  in  1  0 = round-toward-zero, 1 = round-to-nearest-even; sampled per beat into stage 1
- s_valid  in  1  input beat valid
- s_ready  out  1  input accepted when s_valid && s_ready
- s_data  in  LANES*(1+IN_EXP+IN_MAN)  packed operands, lane 0 in LSBs
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accept
- m_data  out  LANES*(1+OUT_EXP+OUT_MAN)  packed results
- m_flags  out  LANES*3  per lane {inexact, underflow, overflow} of the current beat
- clr_flags  in  1  synchronous clear of the sticky flags
- sticky_flags  out  LANES*3  OR of m_flags over all beats handed off since the last clear/reset

Behaviour:
- Interface convention (already decided): reset rstn, asynchronous, active-low; clock aclk.
- Reset values: all stage valid bits 0, m_valid 0, m_data 0, m_flags 0, sticky_flags 0.
- Pipeline structure:
  - S1 registers: classification, sign, re-biased exponent (signed, IN_EXP+2 bits), kept fraction, guard bit, sticky bit, rnd_mode.
  - S2 registers: rounded and packed result plus flags; S2 drives m_*.
- Handshake:
  - adv2 = clken && (!v2 || m_ready)
  - adv1 = clken && (!v1 || adv2)
  - s_ready = adv1 (combinational)
  - Latency is 2 cycles from acceptance to m_valid when unstalled; throughput is 1 beat/cycle.
  - m_data and m_flags hold stable while m_valid && !m_ready.
  - No beat is dropped or duplicated.
- clken = 0: s_ready = 0, all registers hold, m_valid unchanged.
- Reset mid-stream: in-flight beats are discarded. The first beat after rstn release sees s_ready = 1 once clken = 1.
- Exponent arithmetic: e = e_in - (2^(IN_EXP-1)-1) + (2^(OUT_EXP-1)-1).
- Per-lane classification, in priority order:
  - input exp all-ones, frac != 0: canonical qNaN (sign kept, exp all-ones, frac MSB 1, rest 0); no flags.
  - input exp all-ones, frac = 0: signed Inf; no flags.
  - input exp = 0 (zero or subnormal): signed zero. Set inexact if frac != 0, and set underflow if frac != 0.
  - e <= 0: signed zero; underflow = 1, inexact = 1 (no subnormal outputs; flush to zero).
  - e >= 2^OUT_EXP-1: overflow = 1, inexact = 1. RNE gives signed Inf; RTZ gives signed max finite (exp all-ones minus 1, frac all-ones).
  - Otherwise normal:
    - frac_out = top OUT_MAN bits.
    - g = next bit; st = OR of remaining bits.
    - inexact = g | st.
    - RNE increments when g && (st || lsb); RTZ never increments.
    - If the increment carries out of the fraction: frac = 0, e += 1.
    - If e then reaches all-ones: result is Inf, overflow = 1.
- Sticky flags:
  - sticky |= m_flags on each handshake (m_valid && m_ready).
  - clr_flags zeroes sticky. If clr_flags coincides with a handshake, the new beat's flags survive: sticky = m_flags.
  - Sticky update is gated by clken.
- Lanes are fully independent except for the shared handshake.

Decomposition:
- Shared package fp_fmt_pkg:
  - bias and all-ones exponent constants as functions of width
  - flag bit indices (OVF = 0, UNF = 1, INX = 2)
  - rounding-mode encodings
- One natural sub-module: fp_narrow_lane (per-lane classify/round/pack, with S1 and S2 datapath registers), instantiated LANES times.
- The top level owns the valid/ready control, clken gating and sticky flags.

Test Plan:
1. s_data = 0x3F800000, RNE, m_ready = 1 -> m_data = 0x3C00, flags 0, m_valid exactly 2 cycles after acceptance.
2. Rounding:
   - 0x3F803000 RNE -> 0x3C02 inexact; same input RTZ -> 0x3C01.
   - 0x3F801000 RNE -> 0x3C00 inexact (tie to even).
   - 0x3F802000 -> 0x3C01, exact.
3. Overflow:
   - 0x477FF000 RNE -> 0x7C00 with overflow and inexact (rounding carry).
   - Same input RTZ -> 0x7BFF.
   - 0x4F000000 RNE -> 0x7C00, overflow.
4. Underflow and specials:
   - 0x322BCC77 -> 0x0000, unf+inx; 0xB22BCC77 -> 0x8000.
   - NaN 0x7FC00001 -> 0x7E00.
   - 0xFF800000 -> 0xFC00.
   - 0x00000001 -> 0x0000 with unf+inx.
5. Backpressure: stream 8 beats, hold m_ready = 0 for 5 cycles -> s_ready drops after 2 beats are buffered, the output order is preserved, no loss or duplication, and m_data stays stable while stalled.
6. clken, reset and sticky:
   - clken = 0 for 3 cycles mid-stream -> no state change.
   - Assert rstn = 0 with 2 beats in flight -> m_valid = 0 immediately, beats gone.
   - Overflow beat then clr_flags -> sticky_flags clears.
   - LANES = 4 build: per-lane mix of the vectors above -> each lane's result is independent.
